// File: rtl/mips_regfile_sb.sv
// mips_regfile_sb: decode-stage register file with write-through bypass
// and a per-register pending (scoreboard) bit used by issue stall logic.
module mips_regfile_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_READ = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
  output logic [NUM_READ*DATA_W-1:0]   rd_data,
  output logic [NUM_READ-1:0]          rd_busy,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         sb_set,
  input  logic [ADDR_W-1:0]            sb_addr,
  input  logic                         flush,
  output logic                         any_busy
);

  localparam int unsigned DEPTH     = 32'(1) << ADDR_W;
  localparam logic        HasZero   = (ZERO_REG != 0);
  localparam logic        HasBypass = (BYPASS != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busyNext;
  logic              wrAccept;
  logic              sbAccept;

  // Register 0 (when hardwired) swallows both writes and pending marks.
  assign wrAccept = wr_en && !(HasZero && (wr_addr == '0));
  assign sbAccept = sb_set && !flush && !(HasZero && (sb_addr == '0));

  // Data array: one synchronous write port, cleared on reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wrAccept) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Pending-bit update; later assignments win: flush > set > retire.
  always_comb begin
    busyNext = busy;
    if (wrAccept) begin
      busyNext[wr_addr] = 1'b0;
    end
    if (sbAccept) begin
      busyNext[sb_addr] = 1'b1;
    end
    if (flush) begin
      busyNext = '0;
    end
  end

  // Pending array and its registered OR-reduction.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      busy     <= '0;
      any_busy <= 1'b0;
    end else begin
      busy     <= busyNext;
      any_busy <= |busyNext;
    end
  end

  for (genvar g = 0; g < NUM_READ; g++) begin : gRead
    logic [ADDR_W-1:0] portAddr;
    logic [DATA_W-1:0] portData;
    logic              portBusy;

    assign portAddr = rd_addr[g*ADDR_W +: ADDR_W];

    // Read mux: zero register, then same-cycle bypass, then array.
    // Bypass is masked in reset so outputs read zero immediately.
    always_comb begin
      portData = regs[portAddr];
      portBusy = busy[portAddr];
      if (HasZero && (portAddr == '0)) begin
        portData = '0;
        portBusy = 1'b0;
      end else if (HasBypass && resetn && wr_en && (wr_addr == portAddr)) begin
        portData = wr_data;
        portBusy = 1'b0;
      end
    end

    assign rd_data[g*DATA_W +: DATA_W] = portData;
    assign rd_busy[g]                  = portBusy;
  end

endmodule

// File: tb/tb_mips_regfile_sb.sv
// Bench for mips_regfile_sb: default build plus a small build without
// zero register or bypass, both checked every cycle against array models.
module tb_mips_regfile_sb;

  localparam int unsigned AW0 = 5;
  localparam int unsigned DW0 = 32;
  localparam int unsigned NR0 = 2;
  localparam int unsigned AW1 = 3;
  localparam int unsigned DW1 = 16;
  localparam int unsigned NR1 = 4;

  int checks = 0;
  int errors = 0;
  logic checkOn = 1'b0;

  logic clock;
  logic resetn;

  logic [NR0*AW0-1:0] rdAddr0;
  logic [NR0*DW0-1:0] rdData0;
  logic [NR0-1:0]     rdBusy0;
  logic               wrEn0;
  logic [AW0-1:0]     wrAddr0;
  logic [DW0-1:0]     wrData0;
  logic               sbSet0;
  logic [AW0-1:0]     sbAddr0;
  logic               flush0;
  logic               anyBusy0;

  logic [NR1*AW1-1:0] rdAddr1;
  logic [NR1*DW1-1:0] rdData1;
  logic [NR1-1:0]     rdBusy1;
  logic               wrEn1;
  logic [AW1-1:0]     wrAddr1;
  logic [DW1-1:0]     wrData1;
  logic               sbSet1;
  logic [AW1-1:0]     sbAddr1;
  logic               flush1;
  logic               anyBusy1;

  mips_regfile_sb #(.DATA_W(DW0), .ADDR_W(AW0), .NUM_READ(NR0),
                    .ZERO_REG(1), .BYPASS(1)) u0 (
    .clock(clock), .resetn(resetn),
    .rd_addr(rdAddr0), .rd_data(rdData0), .rd_busy(rdBusy0),
    .wr_en(wrEn0), .wr_addr(wrAddr0), .wr_data(wrData0),
    .sb_set(sbSet0), .sb_addr(sbAddr0), .flush(flush0),
    .any_busy(anyBusy0)
  );

  mips_regfile_sb #(.DATA_W(DW1), .ADDR_W(AW1), .NUM_READ(NR1),
                    .ZERO_REG(0), .BYPASS(0)) u1 (
    .clock(clock), .resetn(resetn),
    .rd_addr(rdAddr1), .rd_data(rdData1), .rd_busy(rdBusy1),
    .wr_en(wrEn1), .wr_addr(wrAddr1), .wr_data(wrData1),
    .sb_set(sbSet1), .sb_addr(sbAddr1), .flush(flush1),
    .any_busy(anyBusy1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference state: what each register holds and whether it is pending.
  logic [DW0-1:0] m0Regs [32];
  logic           m0Busy [32];
  logic [DW1-1:0] m1Regs [8];
  logic           m1Busy [8];

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) begin
        m0Regs[i] <= '0;
        m0Busy[i] <= 1'b0;
      end
      for (int i = 0; i < 8; i++) begin
        m1Regs[i] <= '0;
        m1Busy[i] <= 1'b0;
      end
    end else begin
      if (wrEn0 && wrAddr0 != 0) begin
        m0Regs[wrAddr0] <= wrData0;
        m0Busy[wrAddr0] <= 1'b0;
      end
      if (sbSet0 && sbAddr0 != 0) m0Busy[sbAddr0] <= 1'b1;
      if (flush0) for (int i = 0; i < 32; i++) m0Busy[i] <= 1'b0;
      if (wrEn1) begin
        m1Regs[wrAddr1] <= wrData1;
        m1Busy[wrAddr1] <= 1'b0;
      end
      if (sbSet1) m1Busy[sbAddr1] <= 1'b1;
      if (flush1) for (int i = 0; i < 8; i++) m1Busy[i] <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all read ports and any_busy against the model.
  always @(negedge clock) begin
    if (checkOn) begin
      logic [AW0-1:0] a0;
      logic [AW1-1:0] a1;
      logic [DW0-1:0] d0;
      logic [DW1-1:0] d1;
      logic b;
      logic any;
      for (int p = 0; p < int'(NR0); p++) begin
        a0 = rdAddr0[p*AW0 +: AW0];
        if (a0 == 0) begin
          d0 = '0; b = 1'b0;
        end else if (resetn && wrEn0 && wrAddr0 == a0) begin
          d0 = wrData0; b = 1'b0;
        end else begin
          d0 = m0Regs[a0]; b = m0Busy[a0];
        end
        chk($sformatf("u0 rd_data[%0d]", p), 64'(rdData0[p*DW0 +: DW0]), 64'(d0));
        chk($sformatf("u0 rd_busy[%0d]", p), 64'(rdBusy0[p]), 64'(b));
      end
      any = 1'b0;
      for (int i = 0; i < 32; i++) any = any | m0Busy[i];
      chk("u0 any_busy", 64'(anyBusy0), 64'(any));
      for (int p = 0; p < int'(NR1); p++) begin
        a1 = rdAddr1[p*AW1 +: AW1];
        d1 = m1Regs[a1];
        b  = m1Busy[a1];
        chk($sformatf("u1 rd_data[%0d]", p), 64'(rdData1[p*DW1 +: DW1]), 64'(d1));
        chk($sformatf("u1 rd_busy[%0d]", p), 64'(rdBusy1[p]), 64'(b));
      end
      any = 1'b0;
      for (int i = 0; i < 8; i++) any = any | m1Busy[i];
      chk("u1 any_busy", 64'(anyBusy1), 64'(any));
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle0;
    wrEn0 = 1'b0; wrAddr0 = '0; wrData0 = '0;
    sbSet0 = 1'b0; sbAddr0 = '0; flush0 = 1'b0;
  endtask

  task automatic idle1;
    wrEn1 = 1'b0; wrAddr1 = '0; wrData1 = '0;
    sbSet1 = 1'b0; sbAddr1 = '0; flush1 = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    rdAddr0 = '0; rdAddr1 = '0;
    idle0(); idle1();
    #2;
    chk("reset rd_data", 64'(rdData0), 64'h0);
    chk("reset any_busy", 64'(anyBusy0), 64'h0);
    tick(); tick();
    resetn = 1'b1;
    checkOn = 1'b1;

    // Load r1..r31 with distinct nonzero values.
    for (int i = 1; i < 32; i++) begin
      wrEn0 = 1'b1; wrAddr0 = 5'(i); wrData0 = 32'h1000_0000 + 32'(i);
      tick();
    end
    idle0();
    rdAddr0 = {5'd31, 5'd3};
    #1;
    chk("load r3", 64'(rdData0[31:0]), 64'h1000_0003);
    chk("load r31", 64'(rdData0[63:32]), 64'h1000_001F);

    // Hardwired zero register ignores write and pending mark.
    rdAddr0 = {5'd0, 5'd0};
    wrEn0 = 1'b1; wrAddr0 = 5'd0; wrData0 = 32'hDEAD_BEEF;
    #1;
    chk("r0 no bypass", 64'(rdData0[31:0]), 64'h0);
    tick(); idle0();
    sbSet0 = 1'b1; sbAddr0 = 5'd0;
    tick(); idle0();
    #1;
    chk("r0 data", 64'(rdData0), 64'h0);
    chk("r0 busy", 64'(rdBusy0), 64'h0);
    chk("r0 any_busy", 64'(anyBusy0), 64'h0);

    // Same-cycle bypass to both ports.
    rdAddr0 = {5'd5, 5'd5};
    wrEn0 = 1'b1; wrAddr0 = 5'd5; wrData0 = 32'h1234_5678;
    #1;
    chk("bypass both", 64'(rdData0), 64'h1234_5678_1234_5678);
    tick(); idle0();
    #1;
    chk("r5 stored", 64'(rdData0[31:0]), 64'h1234_5678);

    // Scoreboard set, then retire through a bypassed write.
    rdAddr0 = {5'd7, 5'd7};
    sbSet0 = 1'b1; sbAddr0 = 5'd7;
    #1;
    chk("sb same cycle", 64'(rdBusy0), 64'h0);
    tick(); idle0();
    #1;
    chk("r7 busy", 64'(rdBusy0), 64'h3);
    chk("r7 any_busy", 64'(anyBusy0), 64'h1);
    wrEn0 = 1'b1; wrAddr0 = 5'd7; wrData0 = 32'hA5;
    #1;
    chk("r7 retire busy", 64'(rdBusy0), 64'h0);
    chk("r7 retire data", 64'(rdData0[31:0]), 64'hA5);
    chk("r7 any still", 64'(anyBusy0), 64'h1);
    tick(); idle0();
    #1;
    chk("r7 any clear", 64'(anyBusy0), 64'h0);

    // Set and write on the same edge: data lands, pending stays.
    rdAddr0 = {5'd9, 5'd9};
    sbSet0 = 1'b1; sbAddr0 = 5'd9;
    wrEn0 = 1'b1; wrAddr0 = 5'd9; wrData0 = 32'h55;
    tick(); idle0();
    #1;
    chk("r9 data", 64'(rdData0[31:0]), 64'h55);
    chk("r9 busy", 64'(rdBusy0[0]), 64'h1);
    flush0 = 1'b1; sbSet0 = 1'b1; sbAddr0 = 5'd9;
    tick(); idle0();
    #1;
    chk("flush beats set", 64'(rdBusy0), 64'h0);
    chk("flush any", 64'(anyBusy0), 64'h0);

    // Asynchronous reset mid-cycle with work in flight.
    rdAddr0 = {5'd4, 5'd3};
    sbSet0 = 1'b1; sbAddr0 = 5'd3;
    tick(); idle0();
    #1;
    chk("r3 busy pre-reset", 64'(rdBusy0[0]), 64'h1);
    wrEn0 = 1'b1; wrAddr0 = 5'd4; wrData0 = 32'hCAFE;
    sbSet0 = 1'b1; sbAddr0 = 5'd6;
    resetn = 1'b0;
    #1;
    chk("async rst data", 64'(rdData0), 64'h0);
    chk("async rst busy", 64'(rdBusy0), 64'h0);
    chk("async rst any", 64'(anyBusy0), 64'h0);
    tick(); idle0();
    resetn = 1'b1;
    #1;
    chk("post rst data", 64'(rdData0), 64'h0);
    chk("post rst any", 64'(anyBusy0), 64'h0);

    // Build without zero register or bypass.
    rdAddr1 = '0;
    wrEn1 = 1'b1; wrAddr1 = 3'd0; wrData1 = 16'hBEEF;
    #1;
    chk("u1 r0 old", 64'(rdData1[15:0]), 64'h0);
    tick(); idle1();
    #1;
    chk("u1 r0 new", 64'(rdData1), 64'hBEEF_BEEF_BEEF_BEEF);
    rdAddr1 = {3'd5, 3'd5, 3'd5, 3'd5};
    wrEn1 = 1'b1; wrAddr1 = 3'd5; wrData1 = 16'h1234;
    sbSet1 = 1'b1; sbAddr1 = 3'd0;
    #1;
    chk("u1 r5 old", 64'(rdData1[31:16]), 64'h0);
    tick(); idle1();
    rdAddr1 = {3'd0, 3'd0, 3'd5, 3'd5};
    #1;
    chk("u1 r5 new", 64'(rdData1[15:0]), 64'h1234);
    chk("u1 r0 busy", 64'(rdBusy1), 64'hC);
    chk("u1 any", 64'(anyBusy1), 64'h1);

    // Random traffic on both builds with concentrated addresses.
    for (int n = 0; n < 10000; n++) begin
      rdAddr0 = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wrEn0 = ($urandom_range(0, 1) == 1);
      wrAddr0 = 5'($urandom_range(0, 7));
      wrData0 = $urandom();
      sbSet0 = ($urandom_range(0, 3) == 0);
      sbAddr0 = 5'($urandom_range(0, 7));
      flush0 = ($urandom_range(0, 15) == 0);
      rdAddr1 = 12'($urandom());
      wrEn1 = ($urandom_range(0, 1) == 1);
      wrAddr1 = 3'($urandom());
      wrData1 = 16'($urandom());
      sbSet1 = ($urandom_range(0, 3) == 0);
      sbAddr1 = 3'($urandom());
      flush1 = ($urandom_range(0, 15) == 0);
      tick();
    end
    idle0(); idle1();
    tick();
    checkOn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
